proc_datapath: RTL and testbench

Operand datapath and result buffer for the three-operand processor. It sits directly downstream of the sequencing controller and consumes that controller's `capture[2:0]`, `op` and `valid` strobes. It latches operands A, B and C from a shared input bus and computes A*B + C. Each result is pushed into a small FIFO, from which a downstream consumer drains results at its own pace.

---
 rtl/proc_pkg.sv | 16 +
 rtl/result_fifo.sv | 73 +++++++
 rtl/proc_datapath.sv | 70 +++++++
 tb/tb_proc_datapath.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the three-operand processor:
// capture strobe bit positions, default width, result width helper.
package proc_pkg;

    localparam int CAP_A = 0;
    localparam int CAP_B = 1;
    localparam int CAP_C = 2;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int res_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Result buffer: show-ahead FIFO with explicit occupancy count
// and a sticky flag for pushes dropped while full.
module result_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              din,
    input  logic                       pop,
    input  logic                       clr_ovf,
    output logic [DW-1:0]              dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign count    = cnt;
    assign overflow = ovf;
    // Gated so the head reads zero whenever nothing is buffered.
    assign dout     = empty ? '0 : mem[rd_ptr];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
    end

    always_ff @(posedge clock) begin
        if (rst_n && do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            // A drop on the same edge as a clear keeps the flag set.
            if (drop)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/proc_datapath.sv
// Operand registers and A*B+C multiply-add for the three-operand
// processor; results are queued in result_fifo for the consumer.
module proc_datapath
    import proc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [2:0]             capture,
    input  logic                   op,
    input  logic                   valid,
    input  logic                   rd_en,
    input  logic                   clr_ovf,
    output logic [2*WIDTH-1:0]     dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int RW = res_w(WIDTH);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [RW-1:0]    acc_q;
    logic [RW-1:0]    mac;

    // Max (2^W-1)^2 + 2^W-1 still fits in RW bits.
    assign mac = RW'(a_q) * RW'(b_q) + RW'(c_q);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            acc_q <= '0;
        end else begin
            if (capture[CAP_A])
                a_q <= data_in;
            if (capture[CAP_B])
                b_q <= data_in;
            if (capture[CAP_C])
                c_q <= data_in;
            if (op)
                acc_q <= mac;
        end
    end

    result_fifo #(
        .DW    (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .rst_n    (rst_n),
        .push     (valid),
        .din      (acc_q),
        .pop      (rd_en),
        .clr_ovf  (clr_ovf),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_proc_datapath.sv
// Scoreboard bench for proc_datapath: stimulus queues expected
// results, a negedge monitor checks every popped head entry.
module tb_proc_datapath;

    localparam int W = 8;
    localparam int D = 4;

    logic          clock = 1'b0;
    logic          rst_n;
    logic [W-1:0]  data_in;
    logic [2:0]    capture;
    logic          op;
    logic          valid;
    logic          rd_en;
    logic          clr_ovf;
    logic [2*W-1:0] dout;
    logic          empty;
    logic          full;
    logic [2:0]    count;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    logic [15:0] q[$];

    proc_datapath #(.WIDTH(W), .DEPTH(D)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .capture  (capture),
        .op       (op),
        .valid    (valid),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (rst_n && rd_en && !empty) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0d expected none", dout);
            end else begin
                chk("dout_pop", int'(dout), int'(q.pop_front()));
            end
        end
    end

    task automatic cyc(input logic [2:0] cap, input logic [7:0] d,
                       input logic o, input logic v,
                       input logic r, input logic c);
        capture = cap;
        data_in = d;
        op      = o;
        valid   = v;
        rd_en   = r;
        clr_ovf = c;
        @(posedge clock);
        #1;
        capture = 3'b000;
        op      = 1'b0;
        valid   = 1'b0;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
        cyc(3'b001, a, 0, 0, 0, 0);
        cyc(3'b010, b, 0, 0, 0, 0);
        cyc(3'b100, c, 0, 0, 0, 0);
        cyc(3'b000, 0, 1, 0, 0, 0);
    endtask

    task automatic push_res(input logic [15:0] e, input bit accept);
        if (accept)
            q.push_back(e);
        cyc(3'b000, 0, 0, 1, 0, 0);
    endtask

    task automatic pop1();
        cyc(3'b000, 0, 0, 0, 1, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_dout"}, int'(dout), 0);
    endtask

    logic [15:0] wrap_exp [10] = '{16'd2, 16'd9, 16'd18, 16'd29, 16'd42,
                                   16'd57, 16'd74, 16'd93, 16'd114, 16'd137};

    initial begin
        rst_n = 1'b0;
        cyc(3'b000, 0, 0, 0, 0, 0);
        cyc(3'b000, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        chk_reset("rst");

        // basic 3*4+5
        load(8'd3, 8'd4, 8'd5);
        push_res(16'd17, 1);
        chk("basic_dout", int'(dout), 17);
        chk("basic_count", int'(count), 1);
        chk("basic_empty", int'(empty), 0);
        pop1();
        chk("basic_drained", int'(empty), 1);

        // max operands
        load(8'd255, 8'd255, 8'd255);
        push_res(16'd65280, 1);
        chk("max_dout", int'(dout), 65280);
        pop1();

        // fill, overflow, clear collides with drop
        load(8'd1, 8'd2, 8'd3);     push_res(16'd5, 1);
        load(8'd2, 8'd3, 8'd4);     push_res(16'd10, 1);
        load(8'd5, 8'd5, 8'd5);     push_res(16'd30, 1);
        load(8'd10, 8'd10, 8'd10);  push_res(16'd110, 1);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 4);
        chk("fill_ovf0", int'(overflow), 0);
        load(8'd7, 8'd7, 8'd7);
        push_res(16'd56, 0);
        chk("drop_ovf", int'(overflow), 1);
        chk("drop_count", int'(count), 4);
        chk("drop_head", int'(dout), 5);
        cyc(3'b000, 0, 0, 1, 0, 1);
        chk("drop_clr_ovf", int'(overflow), 1);

        // push+pop while full
        q.push_back(16'd56);
        cyc(3'b000, 0, 0, 1, 1, 0);
        chk("pp_count", int'(count), 4);
        chk("pp_full", int'(full), 1);
        chk("pp_head", int'(dout), 10);
        repeat (4) pop1();
        chk("fill_empty", int'(empty), 1);
        chk("fill_ovf_held", int'(overflow), 1);
        cyc(3'b000, 0, 0, 0, 0, 1);
        chk("clr_ovf", int'(overflow), 0);

        // pop while empty
        pop1();
        chk("epop_count", int'(count), 0);
        chk("epop_empty", int'(empty), 1);
        chk("epop_dout", int'(dout), 0);

        // reset mid-operation
        load(8'd3, 8'd3, 8'd3);     push_res(16'd12, 1);
        load(8'd4, 8'd4, 8'd4);     push_res(16'd20, 1);
        cyc(3'b001, 8'd9, 0, 0, 0, 0);
        cyc(3'b010, 8'd9, 0, 0, 0, 0);
        rst_n = 1'b0;
        cyc(3'b000, 0, 0, 0, 0, 0);
        q.delete();
        rst_n = 1'b1;
        chk_reset("mid");
        push_res(16'd0, 1);
        chk("mid_acc0", int'(dout), 0);
        chk("mid_acc0_count", int'(count), 1);
        pop1();
        cyc(3'b100, 8'd1, 0, 0, 0, 0);
        cyc(3'b000, 0, 1, 0, 0, 0);
        push_res(16'd1, 1);
        chk("mid_ab_cleared", int'(dout), 1);
        pop1();
        load(8'd2, 8'd2, 8'd1);
        push_res(16'd5, 1);
        chk("mid_fresh", int'(dout), 5);
        pop1();

        // pointer wrap
        for (int i = 0; i < 10; i++) begin
            load(8'(i + 1), 8'(i + 2), 8'(3 * i));
            push_res(wrap_exp[i], 1);
            chk("wrap_head", int'(dout), int'(wrap_exp[i]));
            pop1();
        end
        chk("wrap_empty", int'(empty), 1);
        chk("sb_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
